stopwatch_counter: RTL
======================

# stopwatch_counter

- Timekeeping core of the stopwatch display. It sits directly upstream of the image-drawing stage.
- It divides the system clock down to a 1 ms tick and keeps an H:MM:SS.mmm count.
- Single-cycle start, lap and clear commands control the count.
- It drives the drawer's `hours`, `minutes`, `seconds`, `milliseconds` and `enable` inputs. While paused, `enable` blinks.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency. The tick divisor `DIV = CLK_HZ/1000` must be ≥ 2.
- `HOURS_MAX`, default 9: highest hour value, ≤ 15.
- `clk` input, 1 bit: the single clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `btn_start` input, 1 bit: start/stop pulse, one cycle, debounced upstream.
- `btn_lap` input, 1 bit: lap freeze/release pulse, one cycle.
- `btn_clear` input, 1 bit: clear pulse, one cycle.
- `hours` output, 4 bits: displayed hours, 0..HOURS_MAX.
- `minutes` output, 6 bits: displayed minutes, 0..59.
- `seconds` output, 6 bits: displayed seconds, 0..59.
- `milliseconds` output, 10 bits: displayed milliseconds, 0..999.
- `enable` output, 1 bit: display enable for the drawer.
- `overflow` output, 1 bit: sticky flag, set when the count saturated.
- `running` output, 1 bit: high in RUNNING or LAP.

## Operation
- States are IDLE, RUNNING, LAP and PAUSED.
- Reset sets the following:
  - state = IDLE
  - count = 0:00:00.000
  - snapshot = 0
  - prescaler = 0
  - all displayed fields = 0
  - `enable` = 1
  - `overflow` = 0
  - `running` = 0
- Command priority within one cycle: clear > start > lap. Lower-priority pulses arriving in the same cycle are dropped.
- `btn_clear` in any state:
  - next state is IDLE;
  - count, snapshot and prescaler are zeroed;
  - `overflow` is cleared.
- IDLE:
  - start → RUNNING;
  - lap is ignored.
- RUNNING:
  - start → PAUSED;
  - lap → LAP, and snapshot ← current count register (pre-increment value).
- LAP:
  - counting continues, but the outputs show the snapshot;
  - lap → RUNNING, live display;
  - start → PAUSED, outputs show the live count.
- PAUSED:
  - start → RUNNING;
  - lap is ignored.
- Counting happens only in RUNNING or LAP. On each ms tick:
  - ms increments; 999 → 0 carries into seconds;
  - seconds 59 → 0 carries into minutes;
  - minutes 59 → 0 carries into hours.
- Saturation: a tick arriving at HOURS_MAX:59:59.999 does the following:
  - the count holds its value;
  - the state goes to PAUSED;
  - `overflow` is set to 1.
  - A later start from this condition returns to RUNNING, but the count stays saturated (the next tick re-pauses).
- Display source: the snapshot in LAP, the live count in every other state.
- `enable`:
  - 1 in IDLE, RUNNING and LAP;
  - in PAUSED it blinks from a ms-tick phase counter: 250 ms on, 250 ms off, starting "on" at pause entry.
  - The prescaler and blink counter keep running in PAUSED; the time count does not.

## Timing
- Prescaler counts 0..DIV−1. The tick is asserted for one cycle when the prescaler is DIV−1.
- The prescaler is zeroed on reset, on clear, and on the IDLE→RUNNING transition.
  - Consequence: the first ms increment lands DIV cycles after the start pulse.
- Outputs are registered, with one cycle of latency:
  - the count register updates on the edge where the tick is sampled high;
  - the displayed fields follow on the next edge.
- State changes take effect on the edge that samples the pulse.
  - `running` and the display source switch one cycle later, together with the fields.
- A tick in the same cycle as start-in-RUNNING is applied; the pause takes effect afterwards.
- A tick in the same cycle as clear is discarded.
- Reset asserted mid-count overrides everything on that edge.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the state enum (IDLE, RUNNING, LAP, PAUSED);
  - the constants MS_MAX = 999, SEC_MAX = 59, MIN_MAX = 59 and BLINK_HALF_MS = 250;
  - the field widths 4/6/6/10.
- One sub-module, `ms_tick_gen`:
  - parameter DIV;
  - inputs `clk`, `rst_n`, `clr`;
  - output `tick`;
  - counter width $clog2(DIV).
- The FSM, BCD-free binary cascade, snapshot and blink logic stay in `stopwatch_counter`.

## Test plan
All scenarios use CLK_HZ = 4000, so DIV = 4.
- **Reset:** hold `rst_n` = 0 for 3 cycles. Check all fields = 0, `enable` = 1, `overflow` = 0, `running` = 0, state IDLE.
- **Start and count:** pulse start, then run 4×1000 cycles. Check the display reads 0:00:01.000, and that ms first reads 1 exactly 5 cycles after the start pulse.
- **Carry chain:** preload by running to 0:00:59.999, then give one more tick. Check 0:01:00.000 next cycle. Repeat at 0:59:59.999 and check 1:00:00.000.
- **Lap:** pulse lap at count 0:00:00.100, then run 200 ms. Check:
  - the display still shows 0:00:00.100;
  - a second lap pulse shows ≈0:00:00.300 live.
- **Pause blink and clear priority:**
  - pause, then check `enable` = 1 for 1000 cycles, 0 for 1000 cycles, repeating, with the fields frozen;
  - give start and clear in the same cycle; check IDLE with count 0.
- **Saturation:** with HOURS_MAX = 0, run to 0:59:59.999 and give one tick. Check:
  - the count holds 0:59:59.999, state is PAUSED, `overflow` = 1;
  - a clear pulse drops `overflow` to 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
// Field widths, saturation limits and the blink half-period live here.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LAP     = 2'd2,
        ST_PAUSED  = 2'd3
    } state_e;

    localparam int HR_W  = 4;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    localparam int MS_W  = 10;

    localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    localparam int BLINK_HALF_MS = 250;
    localparam int BLINK_W       = 9;

    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
        logic [MS_W-1:0]  ms;
    } time_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Divides the system clock to a one-cycle tick every DIV cycles.
// Tick is combinational from the prescaler register; clr restarts the period.
module ms_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: ms prescaler, H:MM:SS.mmm cascade, lap snapshot and pause blink.
// Count updates on the tick edge; displayed fields, running and enable follow one edge later.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int HOURS_MAX = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [3:0]  hours,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic [9:0]  milliseconds,
    output logic        enable,
    output logic        overflow,
    output logic        running
);

    localparam int                 DIV         = CLK_HZ / 1000;
    localparam logic [HR_W-1:0]    HR_MAX      = HR_W'(HOURS_MAX);
    localparam logic [BLINK_W-1:0] BLINK_ON    = BLINK_W'(BLINK_HALF_MS);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(2 * BLINK_HALF_MS - 1);

    state_e              state_q, state_d;
    logic [HR_W-1:0]     hr_q, hr_d;
    logic [MIN_W-1:0]    min_q, min_d;
    logic [SEC_W-1:0]    sec_q, sec_d;
    logic [MS_W-1:0]     ms_q, ms_d;
    time_t               snap_q, snap_d;
    logic [BLINK_W-1:0]  blink_q, blink_d;
    logic                ovf_q, ovf_d;

    logic tick, pre_clr, start_cmd, lap_cmd, counting, at_max, do_tick, saturate;

    assign start_cmd = btn_start & ~btn_clear;
    assign lap_cmd   = btn_lap & ~btn_start & ~btn_clear;
    assign counting  = (state_q == ST_RUNNING) || (state_q == ST_LAP);
    assign at_max    = (hr_q == HR_MAX) && (min_q == MIN_MAX) &&
                       (sec_q == SEC_MAX) && (ms_q == MS_MAX);
    assign do_tick   = tick & counting & ~btn_clear;
    assign saturate  = do_tick & at_max;
    assign pre_clr   = btn_clear | ((state_q == ST_IDLE) & btn_start);

    ms_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_cmd) state_d = ST_RUNNING;
            ST_RUNNING: if (start_cmd) state_d = ST_PAUSED;
                        else if (lap_cmd) state_d = ST_LAP;
            ST_LAP:     if (start_cmd) state_d = ST_PAUSED;
                        else if (lap_cmd) state_d = ST_RUNNING;
            ST_PAUSED:  if (start_cmd) state_d = ST_RUNNING;
            default:    state_d = ST_IDLE;
        endcase
        if (saturate)  state_d = ST_PAUSED;
        if (btn_clear) state_d = ST_IDLE;
    end

    // Binary cascade; at saturation the count simply holds.
    always_comb begin
        ms_d  = ms_q;
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        if (do_tick && !at_max) begin
            if (ms_q != MS_MAX) begin
                ms_d = ms_q + 10'd1;
            end else begin
                ms_d = '0;
                if (sec_q != SEC_MAX) begin
                    sec_d = sec_q + 6'd1;
                end else begin
                    sec_d = '0;
                    if (min_q != MIN_MAX) begin
                        min_d = min_q + 6'd1;
                    end else begin
                        min_d = '0;
                        hr_d  = hr_q + 4'd1;
                    end
                end
            end
        end
        if (btn_clear) begin
            ms_d  = '0;
            sec_d = '0;
            min_d = '0;
            hr_d  = '0;
        end
    end

    always_comb begin
        snap_d = snap_q;
        if ((state_q == ST_RUNNING) && lap_cmd) begin
            snap_d = '{hr: hr_q, min: min_q, sec: sec_q, ms: ms_q};
        end
        if (btn_clear) snap_d = '0;

        ovf_d = ovf_q | saturate;
        if (btn_clear) ovf_d = 1'b0;

        blink_d = blink_q;
        if ((state_q == ST_PAUSED) && tick) begin
            blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
        end
        // Every entry into PAUSED starts the blink in its "on" half.
        if ((state_d == ST_PAUSED) && (state_q != ST_PAUSED)) blink_d = '0;
        if (btn_clear) blink_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hr_q    <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            ms_q    <= '0;
            snap_q  <= '0;
            blink_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            ms_q    <= ms_d;
            snap_q  <= snap_d;
            blink_q <= blink_d;
            ovf_q   <= ovf_d;
        end
    end

    assign overflow = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hours        <= '0;
            minutes      <= '0;
            seconds      <= '0;
            milliseconds <= '0;
            enable       <= 1'b1;
            running      <= 1'b0;
        end else begin
            if (state_q == ST_LAP) begin
                hours        <= snap_q.hr;
                minutes      <= snap_q.min;
                seconds      <= snap_q.sec;
                milliseconds <= snap_q.ms;
            end else begin
                hours        <= hr_q;
                minutes      <= min_q;
                seconds      <= sec_q;
                milliseconds <= ms_q;
            end
            enable  <= (state_q != ST_PAUSED) || (blink_q < BLINK_ON);
            running <= counting;
        end
    end

endmodule
